// File: rtl/cpu_run_ctrl.sv
// Run/step/speed controller: turns board buttons into a one-cycle CPU clock-enable
// at decade-spaced rates, with free-run, single-step and halt modes.
module cpu_run_ctrl #(
    parameter logic [31:0] BASE_DELAY = 32'd100_000_000,
    parameter int          NUM_SPEEDS = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_btn,
    input  logic        step_btn,
    input  logic        speed_btn,
    input  logic        cpu_halt,
    output logic        cpu_en,
    output logic        running,
    output logic [2:0]  speed,
    output logic [31:0] en_count
);

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_STEP = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    localparam logic [2:0] LAST_SPEED = 3'(NUM_SPEEDS - 1);

    function automatic logic [31:0] sat_min1(input logic [31:0] d);
        return (d == 32'd0) ? 32'd1 : d;
    endfunction

    // Repeated floor division by 10 equals floor(BASE_DELAY / 10^k).
    function automatic logic [255:0] build_delays();
        logic [255:0] tab;
        logic [31:0]  d;
        tab = '0;
        d   = BASE_DELAY;
        for (int k = 0; k < 8; k++) begin
            tab[k*32 +: 32] = sat_min1(d);
            d = d / 32'd10;
        end
        return tab;
    endfunction

    localparam logic [255:0] DELAY_TAB = build_delays();

    state_t      state, state_nxt;
    logic [31:0] tick, tick_nxt;
    logic [31:0] delay_cur;
    logic [2:0]  speed_nxt;
    logic        en_nxt;
    logic [2:0]  run_sync, step_sync, speed_sync;
    logic        run_edge, step_edge, speed_edge;

    assign run_edge   = run_sync[1]   & ~run_sync[2];
    assign step_edge  = step_sync[1]  & ~step_sync[2];
    assign speed_edge = speed_sync[1] & ~speed_sync[2];
    assign delay_cur  = DELAY_TAB[32*speed +: 32];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_HALT;
            tick       <= '0;
            speed      <= '0;
            cpu_en     <= 1'b0;
            running    <= 1'b0;
            en_count   <= '0;
            run_sync   <= '0;
            step_sync  <= '0;
            speed_sync <= '0;
        end else begin
            state      <= state_nxt;
            tick       <= tick_nxt;
            speed      <= speed_nxt;
            cpu_en     <= en_nxt;
            running    <= (state_nxt == S_RUN);
            en_count   <= en_count + {31'd0, en_nxt};
            run_sync   <= {run_sync[1:0], run_btn};
            step_sync  <= {step_sync[1:0], step_btn};
            speed_sync <= {speed_sync[1:0], speed_btn};
        end
    end

    // A CPU halt request outranks every button; run beats step when both arrive together.
    always_comb begin
        state_nxt = state;
        case (state)
            S_HALT: begin
                if (!cpu_halt && run_edge)
                    state_nxt = S_RUN;
                else if (!cpu_halt && step_edge)
                    state_nxt = S_STEP;
            end
            S_STEP: state_nxt = S_HALT;
            S_RUN: begin
                if (cpu_halt || run_edge)
                    state_nxt = S_HALT;
            end
            default: state_nxt = S_HALT;
        endcase
    end

    always_comb begin
        en_nxt    = 1'b0;
        tick_nxt  = '0;
        speed_nxt = speed;
        if (speed_edge)
            speed_nxt = (speed == LAST_SPEED) ? 3'd0 : speed + 3'd1;
        case (state)
            S_STEP: en_nxt = 1'b1;
            S_RUN: begin
                // Leaving RUN or changing speed restarts the tick without a pulse.
                if (!cpu_halt && !run_edge && !speed_edge) begin
                    if (tick == delay_cur - 32'd1)
                        en_nxt = 1'b1;
                    else
                        tick_nxt = tick + 32'd1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: reset, run timing, speed cycling, stepping,
// CPU halt priority, reset mid-run and en_count wrap.
module tb_cpu_run_ctrl;

    localparam logic [31:0] BASE = 32'd10000;
    localparam int          NS   = 5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_btn = 1'b0;
    logic        step_btn = 1'b0;
    logic        speed_btn = 1'b0;
    logic        cpu_halt = 1'b0;
    logic        cpu_en;
    logic        running;
    logic [2:0]  speed;
    logic [31:0] en_count;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int pulse_cyc[$];

    typedef struct packed {
        logic       run;
        logic       step;
        logic       spd;
        logic       halt;
        logic       exp_running;
        logic [2:0] exp_speed;
        logic [3:0] exp_delta;
    } vec_t;

    vec_t vecs[9];

    cpu_run_ctrl #(.BASE_DELAY(BASE), .NUM_SPEEDS(NS)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .run_btn(run_btn),
        .step_btn(step_btn),
        .speed_btn(speed_btn),
        .cpu_halt(cpu_halt),
        .cpu_en(cpu_en),
        .running(running),
        .speed(speed),
        .en_count(en_count)
    );

    always #5 clk = ~clk;

    // Cycle index of every observed cpu_en pulse, sampled just after the edge.
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (cpu_en === 1'b1)
            pulse_cyc.push_back(cyc);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input logic r, input logic s, input logic p);
        run_btn   = r;
        step_btn  = s;
        speed_btn = p;
        nclk(1);
        run_btn   = 1'b0;
        step_btn  = 1'b0;
        speed_btn = 1'b0;
    endtask

    task automatic speed_window(input logic [2:0] exp_spd, input int d);
        int base;
        int chg;
        press(1'b0, 1'b0, 1'b1);
        nclk(2);
        chg  = cyc;
        base = pulse_cyc.size();
        check($sformatf("speed_lvl%0d", exp_spd), 32'(speed), 32'(exp_spd));
        nclk(2 * d);
        check($sformatf("pulses_lvl%0d", exp_spd), pulse_cyc.size() - base, 2);
        if (pulse_cyc.size() >= base + 2) begin
            check($sformatf("first_gap_lvl%0d", exp_spd), pulse_cyc[base] - chg, d);
            check($sformatf("spacing_lvl%0d", exp_spd), pulse_cyc[base+1] - pulse_cyc[base], d);
        end
    endtask

    initial begin
        int entry;
        int n;
        int exp_en;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
        vecs[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 4'd1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'd0};
        vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 4'd0};
        vecs[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 4'd0};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1, 4'd0};

        // Reset
        nclk(3);
        check("rst_hold_cpu_en", 32'(cpu_en), 0);
        check("rst_hold_running", 32'(running), 0);
        nclk(2);
        rst_n = 1'b1;
        nclk(1);
        check("rst_cpu_en", 32'(cpu_en), 0);
        check("rst_running", 32'(running), 0);
        check("rst_speed", 32'(speed), 0);
        check("rst_en_count", en_count, 0);
        nclk(20000);
        check("idle_no_pulse", pulse_cyc.size(), 0);

        // Run at speed 0
        press(1'b1, 1'b0, 1'b0);
        nclk(1);
        check("run_latency_early", 32'(running), 0);
        nclk(1);
        check("run_latency", 32'(running), 1);
        entry = cyc;
        nclk(29999);
        check("run_en_count_2", en_count, 2);
        check("run_pre_pulse", 32'(cpu_en), 0);
        nclk(1);
        check("run_en_count_3", en_count, 3);
        check("run_pulse", 32'(cpu_en), 1);
        check("run_pulse_total", pulse_cyc.size(), 3);
        if (pulse_cyc.size() >= 3) begin
            check("run_first_gap", pulse_cyc[0] - entry, 10000);
            check("run_gap_1", pulse_cyc[1] - pulse_cyc[0], 10000);
            check("run_gap_2", pulse_cyc[2] - pulse_cyc[1], 10000);
        end

        // Speed cycling
        speed_window(3'd1, 1000);
        speed_window(3'd2, 100);
        speed_window(3'd3, 10);
        speed_window(3'd4, 1);
        press(1'b0, 1'b0, 1'b1);
        nclk(1);
        check("lvl4_continuous", 32'(cpu_en), 1);
        nclk(1);
        check("speed_wrap", 32'(speed), 0);
        check("speed_edge_no_pulse", 32'(cpu_en), 0);
        press(1'b1, 1'b0, 1'b0);
        nclk(2);
        check("halt_by_run", 32'(running), 0);
        nclk(2);

        // Stepping and halt-request table
        check("en_count_vs_pulses", en_count, pulse_cyc.size());
        exp_en = pulse_cyc.size();
        for (int i = 0; i < 9; i++) begin
            cpu_halt = vecs[i].halt;
            press(vecs[i].run, vecs[i].step, vecs[i].spd);
            nclk(5);
            exp_en = exp_en + int'(vecs[i].exp_delta);
            check($sformatf("vec%0d_running", i), 32'(running), 32'(vecs[i].exp_running));
            check($sformatf("vec%0d_speed", i), 32'(speed), 32'(vecs[i].exp_speed));
            check($sformatf("vec%0d_en_count", i), en_count, exp_en);
            check($sformatf("vec%0d_pulses", i), pulse_cyc.size(), exp_en);
        end
        cpu_halt = 1'b0;

        // CPU halt in RUN at speed 4
        repeat (3) begin
            press(1'b0, 1'b0, 1'b1);
            nclk(3);
        end
        check("halt_setup_speed", 32'(speed), 4);
        press(1'b1, 1'b0, 1'b0);
        nclk(2);
        check("halt_run_entry", 32'(running), 1);
        check("halt_first_cycle_no_pulse", 32'(cpu_en), 0);
        nclk(5);
        check("halt_run_continuous", 32'(cpu_en), 1);
        cpu_halt = 1'b1;
        nclk(1);
        check("cpu_halt_running", 32'(running), 0);
        check("cpu_halt_no_pulse", 32'(cpu_en), 0);
        n = pulse_cyc.size();
        press(1'b1, 1'b1, 1'b0);
        nclk(5);
        check("cpu_halt_ignores_running", 32'(running), 0);
        check("cpu_halt_ignores_pulses", pulse_cyc.size(), n);
        cpu_halt = 1'b0;
        press(1'b1, 1'b0, 1'b0);
        nclk(2);
        check("rerun_running", 32'(running), 1);
        nclk(1);
        check("rerun_pulse", 32'(cpu_en), 1);
        nclk(3);
        press(1'b1, 1'b0, 1'b0);
        nclk(1);
        check("run_stop_before", 32'(cpu_en), 1);
        nclk(1);
        check("run_stop_running", 32'(running), 0);
        check("run_stop_no_pulse", 32'(cpu_en), 0);

        // Reset just before a terminal tick at speed 3
        repeat (4) begin
            press(1'b0, 1'b0, 1'b1);
            nclk(3);
        end
        check("mid_setup_speed", 32'(speed), 3);
        press(1'b1, 1'b0, 1'b0);
        nclk(2);
        check("mid_running", 32'(running), 1);
        entry = cyc;
        nclk(9);
        check("mid_pre_terminal", 32'(cpu_en), 0);
        n = pulse_cyc.size();
        rst_n = 1'b0;
        nclk(1);
        check("mid_rst_cpu_en", 32'(cpu_en), 0);
        check("mid_rst_running", 32'(running), 0);
        check("mid_rst_speed", 32'(speed), 0);
        check("mid_rst_en_count", en_count, 0);
        check("mid_rst_no_pulse", pulse_cyc.size(), n);
        rst_n = 1'b1;
        nclk(2);

        // en_count wrap
        force dut.en_count = 32'hFFFF_FFFF;
        release dut.en_count;
        nclk(1);
        check("wrap_preset", en_count, 32'hFFFF_FFFF);
        press(1'b0, 1'b1, 1'b0);
        nclk(3);
        check("wrap_step_pulse", 32'(cpu_en), 1);
        check("wrap_en_count", en_count, 0);
        nclk(1);
        check("wrap_single_pulse", 32'(cpu_en), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
